// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage ALU with registered single-cycle ops and iterative signed MULT/MADD
// Optional feature macro: ALU_OVF_EN (adds ovf output for signed ADD/SUB overflow)
module alu_exec_seq #(
  parameter int W       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         ALUctl,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [W-1:0]       result,
  output logic               zero,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       hi,
  output logic [W-1:0]       lo
`ifdef ALU_OVF_EN
  ,
  output logic               ovf
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  localparam logic [3:0]         OP_MULT = 4'b1011;
  localparam logic [3:0]         OP_MADD = 4'b1101;
  localparam logic [SHAMT_W-1:0] LAST    = SHAMT_W'(W - 1);

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic [2*W-1:0]     prod;
  logic [2*W-1:0]     mcand;
  logic [W-1:0]       mplier;
  logic               sign;
  logic               is_madd;

  logic [W-1:0]       sum, diff, alu_f, abs_a, abs_b;
  logic [2*W-1:0]     sprod, acc_new;
  logic               is_mul_op;

  always_comb begin
    sum   = a + b;
    diff  = a - b;
    alu_f = '0;
    case (ALUctl)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = sum;
      4'b0011: alu_f = {b[15:0], {(W-16){1'b0}}};
      4'b0100: alu_f = a ^ b;
      4'b0101: alu_f = ~(a | b);
      4'b0110: alu_f = diff;
      4'b0111: alu_f = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1000: alu_f = b << shamt;
      4'b1001: alu_f = b >> shamt;
      4'b1010: alu_f = $unsigned($signed(b) >>> shamt);
      4'b1100: alu_f = a;
      4'b1110: alu_f = diff;
      4'b1111: alu_f = b;
      default: alu_f = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic alu_ovf;
  always_comb begin
    alu_ovf = 1'b0;
    if (ALUctl == 4'b0010)
      alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    else if (ALUctl == 4'b0110)
      alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
  end
`endif

  // Magnitudes feed an unsigned shift-add; the sign is reapplied in FIN.
  always_comb begin
    is_mul_op = (ALUctl == OP_MULT) || (ALUctl == OP_MADD);
    abs_a     = a[W-1] ? (~a + 1'b1) : a;
    abs_b     = b[W-1] ? (~b + 1'b1) : b;
    sprod     = sign ? (~prod + 1'b1) : prod;
    acc_new   = is_madd ? ({hi, lo} + sprod) : sprod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      sign    <= 1'b0;
      is_madd <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef ALU_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul_op) begin
              mcand   <= {{W{1'b0}}, abs_a};
              mplier  <= abs_b;
              prod    <= '0;
              sign    <= a[W-1] ^ b[W-1];
              is_madd <= (ALUctl == OP_MADD);
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= MUL;
            end else begin
              result <= alu_f;
              zero   <= (alu_f == '0);
              done   <= 1'b1;
`ifdef ALU_OVF_EN
              ovf    <= alu_ovf;
`endif
            end
          end
        end
        MUL: begin
          if (mplier[0])
            prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST)
            state <= FIN;
        end
        FIN: begin
          hi     <= acc_new[2*W-1:W];
          lo     <= acc_new[W-1:0];
          result <= acc_new[W-1:0];
          zero   <= (acc_new[W-1:0] == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
`ifdef ALU_OVF_EN
          ovf    <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - randomized self-checking bench for alu_exec_seq against a behavioural model
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ALUctl;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int errs = 0;
  int nchk = 0;

  logic [63:0] m_acc;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  alu_exec_seq dut (
    .clk(clk), .rst(rst), .start(start), .ALUctl(ALUctl), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] x,
                                         input logic [31:0] y, input logic [4:0] s);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (c)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return y * 32'h10000;
      4'd4:  return x ^ y;
      4'd5:  return ~(x | y);
      4'd6:  return x - y;
      4'd7:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  return y << s;
      4'd9:  return y >> s;
      4'd10: return $unsigned(sy >>> s);
      4'd12: return x;
      4'd14: return x - y;
      4'd15: return y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    longint r;
    if (c == 4'd2)      r = longint'($signed(x)) + longint'($signed(y));
    else if (c == 4'd6) r = longint'($signed(x)) - longint'($signed(y));
    else                return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic single(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] s);
    ALUctl = c; a = x; b = y; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_res = ref_op(c, x, y, s);
    chk($sformatf("res op%0d", c), {32'd0, result}, {32'd0, m_res});
    chk("zero", {63'd0, zero}, {63'd0, (m_res == 32'd0)});
    chk("done", {63'd0, done}, 64'd1);
    chk("hilo kept", {hi, lo}, m_acc);
`ifdef ALU_OVF_EN
    chk("ovf", {63'd0, ovf}, {63'd0, ref_ovf(c, x, y)});
`endif
  endtask

  task automatic mul(input logic madd, input logic [31:0] x, input logic [31:0] y, input logic poke);
    int n;
    logic [63:0] p;
    ALUctl = madd ? 4'b1101 : 4'b1011; a = x; b = y; shamt = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = poke;
    ALUctl = 4'b0010; a = 32'h1; b = 32'h2;
    chk("busy set", {63'd0, busy}, 64'd1);
    p = 64'(longint'($signed(x)) * longint'($signed(y)));
    m_acc = madd ? (m_acc + p) : p;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 4) start = 1'b0;
      if (n == 10) chk("res held", {32'd0, result}, {32'd0, m_res});
    end
    m_res = m_acc[31:0];
    chk("mul latency", 64'(n), 64'd33);
    chk("mul hi", {32'd0, hi}, {32'd0, m_acc[63:32]});
    chk("mul lo", {32'd0, lo}, {32'd0, m_acc[31:0]});
    chk("mul res", {32'd0, result}, {32'd0, m_res});
    chk("mul zero", {63'd0, zero}, {63'd0, (m_res == 32'd0)});
    chk("busy clr", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("done pulse", {63'd0, done}, 64'd0);
  endtask

  function automatic logic [31:0] rval();
    logic [31:0] edges [4];
    edges[0] = 32'h0; edges[1] = 32'h7FFFFFFF; edges[2] = 32'h80000000; edges[3] = 32'hFFFFFFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    logic [3:0] c;
    rst = 1'b1; start = 1'b1; ALUctl = 4'b0010; a = 32'h5; b = 32'h6; shamt = 5'd0;
    @(posedge clk); @(posedge clk); #1;
    m_acc = 64'd0; m_res = 32'd0;
    chk("rst result", {32'd0, result}, 64'd0);
    chk("rst zero", {63'd0, zero}, 64'd1);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    single(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    single(4'b1010, 32'h0, 32'h80000000, 5'd4);
    single(4'b0011, 32'h0, 32'h1234, 5'd0);
    mul(1'b0, 32'hFFFFFFFE, 32'h3, 1'b1);
    mul(1'b0, 32'h10000, 32'h10000, 1'b0);
    mul(1'b1, 32'h2, 32'h3, 1'b0);
    mul(1'b0, 32'h80000000, 32'h80000000, 1'b0);

    for (int i = 0; i < 150; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'b1011 || c == 4'b1101) c = 4'b0110;
      single(c, rval(), rval(), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 6; i++)
      mul(1'($urandom_range(0, 1)), rval(), rval(), 1'($urandom_range(0, 1)));

    ALUctl = 4'b1011; a = 32'h1234567; b = 32'h89ABCDE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = 64'd0; m_res = 32'd0;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort hilo", {hi, lo}, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    single(4'b0010, 32'h11, 32'h22, 5'd0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
